// File: rtl/debounce_pkg.sv
// Shared types and constants for the debounce_edge block.
package debounce_pkg;

   typedef logic [1:0] deb_state_t;

   localparam deb_state_t S_LOW       = 2'd0;
   localparam deb_state_t S_WAIT_HIGH = 2'd1;
   localparam deb_state_t S_HIGH      = 2'd2;
   localparam deb_state_t S_WAIT_LOW  = 2'd3;

   localparam int unsigned EVENT_CNT_W = 8;

endpackage

// File: rtl/stable_counter.sv
// Stability counter for debounce_edge: clear, saturating increment, and a done
// flag raised when the count reaches STABLE_CYCLES-1.
module stable_counter #(
   parameter int unsigned STABLE_CYCLES = 4,
   parameter int unsigned CNT_W         = $clog2(STABLE_CYCLES) + 1
) (
   input  logic clk,
   input  logic reset,
   input  logic clr_i,
   input  logic inc_i,
   output logic done_o
);

   localparam logic [CNT_W-1:0] Last = CNT_W'(STABLE_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q != Last)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign done_o = (cnt_q == Last);

endmodule

// File: rtl/debounce_edge.sv
// Debounces a synchronous level and emits registered one-cycle rise/fall pulses.
// Optional rise counter enabled by defining DEBOUNCE_EDGE_EVENT_CNT_EN.
module debounce_edge
   import debounce_pkg::*;
#(
   parameter int unsigned STABLE_CYCLES = 4,
   parameter int unsigned CNT_W         = $clog2(STABLE_CYCLES) + 1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   d,
   output logic                   level,
   output logic                   rise,
   output logic                   fall,
   output logic [EVENT_CNT_W-1:0] event_cnt
);

   deb_state_t state_q, state_d;
   logic       level_q, level_d;
   logic       rise_q, rise_d;
   logic       fall_q, fall_d;
   logic       cnt_clr, cnt_inc, cnt_done;

   stable_counter #(
      .STABLE_CYCLES(STABLE_CYCLES),
      .CNT_W        (CNT_W)
   ) u_stable_counter (
      .clk   (clk),
      .reset (reset),
      .clr_i (cnt_clr),
      .inc_i (cnt_inc),
      .done_o(cnt_done)
   );

   // Entering a wait state increments from 0, so the first qualifying sample counts as 1.
   always_comb begin
      state_d = state_q;
      level_d = level_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      cnt_clr = 1'b0;
      cnt_inc = 1'b0;
      case (state_q)
         S_LOW: begin
            if (d) begin
               state_d = S_WAIT_HIGH;
               cnt_inc = 1'b1;
            end else begin
               cnt_clr = 1'b1;
            end
         end
         S_WAIT_HIGH: begin
            if (!d) begin
               state_d = S_LOW;
               cnt_clr = 1'b1;
            end else if (cnt_done) begin
               state_d = S_HIGH;
               level_d = 1'b1;
               rise_d  = 1'b1;
               cnt_clr = 1'b1;
            end else begin
               cnt_inc = 1'b1;
            end
         end
         S_HIGH: begin
            if (!d) begin
               state_d = S_WAIT_LOW;
               cnt_inc = 1'b1;
            end else begin
               cnt_clr = 1'b1;
            end
         end
         S_WAIT_LOW: begin
            if (d) begin
               state_d = S_HIGH;
               cnt_clr = 1'b1;
            end else if (cnt_done) begin
               state_d = S_LOW;
               level_d = 1'b0;
               fall_d  = 1'b1;
               cnt_clr = 1'b1;
            end else begin
               cnt_inc = 1'b1;
            end
         end
         default: begin
            state_d = S_LOW;
            level_d = 1'b0;
            cnt_clr = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_LOW;
         level_q <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         level_q <= level_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
      end
   end

   assign level = level_q;
   assign rise  = rise_q;
   assign fall  = fall_q;

`ifdef DEBOUNCE_EDGE_EVENT_CNT_EN
   logic [EVENT_CNT_W-1:0] event_cnt_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         event_cnt_q <= '0;
      end else if (rise_d) begin
         event_cnt_q <= event_cnt_q + EVENT_CNT_W'(1);
      end
   end

   assign event_cnt = event_cnt_q;
`else
   assign event_cnt = '0;
`endif

endmodule

// File: tb/tb_debounce_edge.sv
// Directed self-checking bench for debounce_edge with STABLE_CYCLES=4.
module tb_debounce_edge;

   logic       clk = 1'b0;
   logic       reset;
   logic       d;
   logic       level;
   logic       rise;
   logic       fall;
   logic [7:0] event_cnt;

   int total = 0;
   int bad   = 0;

   debounce_edge #(
      .STABLE_CYCLES(4)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .d        (d),
      .level    (level),
      .rise     (rise),
      .fall     (fall),
      .event_cnt(event_cnt)
   );

   always #5 clk = ~clk;

   // Expected event_cnt after n rises since the last reset, for either build.
   function automatic logic [7:0] ev_exp(input int n);
`ifdef DEBOUNCE_EDGE_EVENT_CNT_EN
      return 8'(n % 256);
`else
      return 8'd0;
`endif
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      d     = 1'b0;
      step();
      step();
      total++;
      if ({level, rise, fall} !== 3'b000) begin
         bad++;
         $display("FAIL reset_outs: got lrf=%b want 000", {level, rise, fall});
      end
      total++;
      if (event_cnt !== 8'd0) begin
         bad++;
         $display("FAIL reset_evcnt: got %0d want 0", event_cnt);
      end
      reset = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         total++;
         if ({level, rise, fall} !== 3'b000) begin
            bad++;
            $display("FAIL idle_low[%0d]: got lrf=%b want 000", i, {level, rise, fall});
         end
      end
      total++;
      if (event_cnt !== 8'd0) begin
         bad++;
         $display("FAIL idle_evcnt: got %0d want 0", event_cnt);
      end
   endtask

   task automatic test_rise();
      d = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         step();
         total++;
         if ({level, rise, fall} !== 3'b000) begin
            bad++;
            $display("FAIL rise_early[%0d]: got lrf=%b want 000", i, {level, rise, fall});
         end
      end
      step();
      total++;
      if ({level, rise, fall} !== 3'b110) begin
         bad++;
         $display("FAIL rise_pulse: got lrf=%b want 110", {level, rise, fall});
      end
      total++;
      if (event_cnt !== ev_exp(1)) begin
         bad++;
         $display("FAIL rise_evcnt: got %0d want %0d", event_cnt, ev_exp(1));
      end
      for (int i = 0; i < 4; i++) begin
         step();
         total++;
         if ({level, rise, fall} !== 3'b100) begin
            bad++;
            $display("FAIL rise_hold[%0d]: got lrf=%b want 100", i, {level, rise, fall});
         end
      end
   endtask

   task automatic test_glitch_low();
      d = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         total++;
         if ({level, rise, fall} !== 3'b100) begin
            bad++;
            $display("FAIL glitch_n1[%0d]: got lrf=%b want 100", i, {level, rise, fall});
         end
      end
      d = 1'b1;
      step();
      total++;
      if ({level, rise, fall} !== 3'b100) begin
         bad++;
         $display("FAIL glitch_back: got lrf=%b want 100", {level, rise, fall});
      end
      d = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         step();
         total++;
         if ({level, rise, fall} !== 3'b100) begin
            bad++;
            $display("FAIL fall_early[%0d]: got lrf=%b want 100", i, {level, rise, fall});
         end
      end
      step();
      total++;
      if ({level, rise, fall} !== 3'b001) begin
         bad++;
         $display("FAIL fall_pulse: got lrf=%b want 001", {level, rise, fall});
      end
      step();
      total++;
      if ({level, rise, fall} !== 3'b000) begin
         bad++;
         $display("FAIL fall_after: got lrf=%b want 000", {level, rise, fall});
      end
      total++;
      if (event_cnt !== ev_exp(1)) begin
         bad++;
         $display("FAIL fall_evcnt: got %0d want %0d", event_cnt, ev_exp(1));
      end
   endtask

   task automatic test_toggle();
      for (int i = 0; i < 50; i++) begin
         d = (i % 2 == 0);
         step();
         total++;
         if ({level, rise, fall} !== 3'b000) begin
            bad++;
            $display("FAIL toggle[%0d]: got lrf=%b want 000", i, {level, rise, fall});
         end
      end
      // N-1 cycle high glitch must also be rejected.
      for (int i = 0; i < 5; i++) begin
         d = (i < 3);
         step();
         total++;
         if ({level, rise, fall} !== 3'b000) begin
            bad++;
            $display("FAIL glitch_hi[%0d]: got lrf=%b want 000", i, {level, rise, fall});
         end
      end
   endtask

   task automatic test_reset_mid();
      d = 1'b1;
      step();
      step();
      reset = 1'b1;
      step();
      total++;
      if ({level, rise, fall} !== 3'b000) begin
         bad++;
         $display("FAIL midrst_outs: got lrf=%b want 000", {level, rise, fall});
      end
      total++;
      if (event_cnt !== 8'd0) begin
         bad++;
         $display("FAIL midrst_evcnt: got %0d want 0", event_cnt);
      end
      reset = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         step();
         total++;
         if ({level, rise, fall} !== 3'b000) begin
            bad++;
            $display("FAIL midrst_early[%0d]: got lrf=%b want 000", i, {level, rise, fall});
         end
      end
      step();
      total++;
      if ({level, rise, fall} !== 3'b110) begin
         bad++;
         $display("FAIL midrst_rise: got lrf=%b want 110", {level, rise, fall});
      end
      total++;
      if (event_cnt !== ev_exp(1)) begin
         bad++;
         $display("FAIL midrst_evcnt2: got %0d want %0d", event_cnt, ev_exp(1));
      end
   endtask

   task automatic test_wrap();
      int rises;
      int falls;
      int overlap;
      rises   = 0;
      falls   = 0;
      overlap = 0;
      reset   = 1'b1;
      d       = 1'b0;
      step();
      reset = 1'b0;
      for (int p = 0; p < 256; p++) begin
         d = 1'b1;
         for (int k = 0; k < 4; k++) begin
            step();
            rises += int'(rise);
            falls += int'(fall);
            overlap += int'(rise & fall);
         end
         if (p == 254) begin
            total++;
            if (event_cnt !== ev_exp(255)) begin
               bad++;
               $display("FAIL wrap_255: got %0d want %0d", event_cnt, ev_exp(255));
            end
         end
         d = 1'b0;
         for (int k = 0; k < 4; k++) begin
            step();
            rises += int'(rise);
            falls += int'(fall);
            overlap += int'(rise & fall);
         end
      end
      total++;
      if (rises != 256) begin
         bad++;
         $display("FAIL wrap_rises: got %0d want 256", rises);
      end
      total++;
      if (falls != 256) begin
         bad++;
         $display("FAIL wrap_falls: got %0d want 256", falls);
      end
      total++;
      if (overlap != 0) begin
         bad++;
         $display("FAIL wrap_overlap: got %0d want 0", overlap);
      end
      total++;
      if (event_cnt !== ev_exp(256)) begin
         bad++;
         $display("FAIL wrap_256: got %0d want %0d", event_cnt, ev_exp(256));
      end
   endtask

   initial begin
      reset = 1'b1;
      d     = 1'b0;
      test_reset();
      test_rise();
      test_glitch_low();
      test_toggle();
      test_reset_mid();
      test_wrap();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
